i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) on the same two-wire bus that i2c_master drives; 7-bit addressing, standard single-target use.
- Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its own address, and receives write bytes or transmits read bytes.
- Presents a simple byte-level interface to local logic.

Parameters:
- SLAVE_ADDR, 7'h10, own 7-bit bus address.
- SYNC_STAGES, 2, synchronizer depth on SCL/SDA inputs (min 2).

Ports:
- clk  in  1  system clock; at least 8x the SCL frequency.
- rst_n  in  1  asynchronous, active-low reset.
- scl  in  1  bus clock from master.
- sda  inout  1  bus data; driven only to 0 (open-drain), else 1'bz.
- en_sda  out  1  1 = slave pulling SDA low; sda = en_sda ? 1'b0 : 1'bz.
- rx_data  out  8  last received write byte.
- rx_valid  out  1  one-clk pulse, rx_data updated.
- tx_data  in  8  byte to send on a read.
- tx_req  out  1  one-clk pulse requesting the next tx_data.
- rw  out  1  R/W bit of the current addressed transfer.
- busy  out  1  high from address match until STOP/NACK/mismatch.

Behaviour:
- Reset values: en_sda=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0; FSM in IDLE, bit counter 0.
- Inputs pass through SYNC_STAGES flops; edges are detected on synced values (prev vs current).
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
- Data is sampled on synced SCL rise. en_sda changes only on synced SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE: START goes to ADDR, bit counter cleared.
  - ADDR: shifts 8 bits MSB first (7 address bits + R/W).
    - On the 8th SCL rise, if the match holds: latch rw, set busy. At the following SCL fall, en_sda=1 (ACK) and go to ADDR_ACK.
    - On mismatch: go to WAIT_STOP and never drive SDA.
  - ADDR_ACK: the SCL fall ending the 9th clock releases en_sda, then:
    - rw=0: go to WR_BYTE.
    - rw=1: go to RD_BYTE, load the shift register from tx_data, and drive bit 7 on that same fall.
  - WR_BYTE: shifts 8 bits.
    - On the 8th rise: rx_data is updated and rx_valid pulses for exactly one clk.
    - At the next fall: en_sda=1 and go to WR_ACK.
  - WR_ACK: the fall ending the 9th clock releases SDA and returns to WR_BYTE.
  - RD_BYTE: on each SCL fall, en_sda = ~shift[7], then shift left.
    - After the 8th bit's fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on the 9th SCL rise.
    - 0 (ACK): pulse tx_req; tx_data must be stable within 2 clks. Latch tx_data on the next SCL fall and go to RD_BYTE.
    - 1 (NACK): go to WAIT_STOP and clear busy.
  - tx_req also pulses once on the ADDR-match rise when rw=1.
  - WAIT_STOP: SDA released. STOP goes to IDLE; START goes to ADDR.
- Priority and abort rules:
  - STOP in any state goes to IDLE, releases SDA, clears busy.
  - START in any state (repeated START) goes to ADDR, releases SDA, clears busy.
  - START/STOP take priority over bit processing in the same clk.
- General call (address 0) is not acknowledged.
- The slave never stretches SCL.
- Reset mid-transfer: immediate release of SDA; FSM to IDLE regardless of bus state. The slave stays idle until the next START.

Optional Feature:
- I2C_GLITCH_FILTER_EN: defined inserts a 3-sample majority filter after the synchronizers on both SCL and SDA. This adds 1 clk of latency and rejects pulses of 1 clk or less.
- Undefined: synced signals are used directly.

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state enum (i2c_slv_state_t);
  - constants I2C_ADDR_W=7, I2C_DATA_W=8, I2C_BITS_PER_BYTE=8.
- One sub-module: i2c_sync_edge. It contains the synchronizer, the optional filter, and rise/fall outputs, and is instantiated twice (SCL, SDA).

Test Plan:
- Write 7'h10 W, then data 8'hA5 and a STOP:
  - en_sda low during both 9th clocks;
  - rx_data=8'hA5, one rx_valid pulse;
  - busy falls at STOP.
- Address 7'h59 W: en_sda stays 0 for the whole transfer, busy stays 0, and no rx_valid.
- Read 7'h10 R, tx_data=8'h3C then 8'hC3, master ACK then NACK:
  - SDA bits read 3C, C3;
  - tx_req pulses twice;
  - SDA released after NACK; FSM in WAIT_STOP until STOP.
- Write 7'h10 W, byte 8'h01, then repeated START with 7'h10 R:
  - rx_data=8'h01;
  - the read proceeds with rw=1 and no STOP in between.
- Assert rst_n=0 during the 4th data bit of a read: en_sda=0 within the same clk edge, and all outputs take their reset values.
- With I2C_GLITCH_FILTER_EN defined, inject a 1-clk high glitch on SCL mid-bit: no extra bit is shifted, and 8'hA5 is still received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-width constants.
package i2c_pkg;

    localparam int I2C_ADDR_W        = 7;
    localparam int I2C_DATA_W        = 8;
    localparam int I2C_BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus and byte-level signal bundle for the I2C target.
// sda is the resolved open-drain line value as seen on the wire. The target never
// drives it directly; en_sda is its pull-down enable (line = en_sda ? 0 : released),
// and the owner of the wire resolves all pull-downs against the pull-up.
interface i2c_slave_if;

    logic                            scl;
    wire                             sda;
    logic                            en_sda;
    logic [i2c_pkg::I2C_DATA_W-1:0]  rx_data;
    logic                            rx_valid;
    logic [i2c_pkg::I2C_DATA_W-1:0]  tx_data;
    logic                            tx_req;
    logic                            rw;
    logic                            busy;

    modport slave (
        input  scl,
        input  sda,
        output en_sda,
        output rx_data,
        output rx_valid,
        input  tx_data,
        output tx_req,
        output rw,
        output busy
    );

    modport master (
        output scl,
        input  sda,
        input  en_sda,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        input  tx_req,
        input  rw,
        input  busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Input conditioner for one I2C line: synchronizer chain, optional glitch filter
// (macro I2C_GLITCH_FILTER_EN: 3-sample majority, +1 clk latency, rejects 1-clk pulses),
// and rise/fall strobes derived from the conditioned level.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   clean;
    logic                   prev;

    // Metastability chain; resets high because an idle I2C line is pulled up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], din};
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist;

    // Two-deep history of synced samples feeding the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '1;
        else        hist <= {hist[0], sync[SYNC_STAGES-1]};
    end

    assign clean = (sync[SYNC_STAGES-1] & hist[0]) |
                   (sync[SYNC_STAGES-1] & hist[1]) |
                   (hist[0] & hist[1]);
`else
    assign clean = sync[SYNC_STAGES-1];
`endif

    // Previous conditioned sample, used to form the edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= clean;
    end

    assign level = clean;
    assign rise  = clean & ~prev;
    assign fall  = ~clean & prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing: detects START/STOP on oversampled SCL/SDA,
// ACKs its own address, receives write bytes and transmits read bytes.
// Macro I2C_GLITCH_FILTER_EN enables the majority glitch filter in i2c_sync_edge.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h10,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    i2c_slave_if.slave  bus
);

    localparam logic [3:0] LAST_BIT  = 4'(I2C_BITS_PER_BYTE - 1);
    localparam logic [3:0] FULL_BYTE = 4'(I2C_BITS_PER_BYTE);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det, addr_match, load_tx;

    i2c_slv_state_t          state, state_nx;
    logic [3:0]              cnt, cnt_nx;
    logic [I2C_DATA_W-1:0]   shift, shift_nx, shifted_in;
    logic [I2C_DATA_W-1:0]   rx_data_q, rx_data_nx;
    logic                    en_q, en_nx, rx_valid_q, rx_valid_nx;
    logic                    tx_req_q, tx_req_nx, rw_q, rw_nx, busy_q, busy_nx;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst_n(rst_n), .din(bus.scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst_n(rst_n), .din(bus.sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign shifted_in = {shift[I2C_DATA_W-2:0], sda_lvl};
    // Address 0 (general call) can never match, whatever SLAVE_ADDR is set to.
    assign addr_match = (shifted_in[7:1] == SLAVE_ADDR) && (shifted_in[7:1] != '0);

    // State and output registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            en_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            shift      <= shift_nx;
            en_q       <= en_nx;
            rx_data_q  <= rx_data_nx;
            rx_valid_q <= rx_valid_nx;
            tx_req_q   <= tx_req_nx;
            rw_q       <= rw_nx;
            busy_q     <= busy_nx;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit processing on SCL edges.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shift_nx    = shift;
        en_nx       = en_q;
        rx_data_nx  = rx_data_q;
        rx_valid_nx = 1'b0;
        tx_req_nx   = 1'b0;
        rw_nx       = rw_q;
        busy_nx     = busy_q;
        load_tx     = 1'b0;

        if (stop_det) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
        end else if (start_det) begin
            state_nx = ADDR;
            cnt_nx   = '0;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise && cnt < FULL_BYTE) begin
                        shift_nx = shifted_in;
                        cnt_nx   = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            if (addr_match) begin
                                rw_nx     = sda_lvl;
                                busy_nx   = 1'b1;
                                tx_req_nx = sda_lvl;
                            end else begin
                                state_nx  = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && cnt == FULL_BYTE) begin
                        en_nx    = 1'b1;
                        state_nx = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        en_nx    = 1'b0;
                        cnt_nx   = '0;
                        state_nx = WR_BYTE;
                        load_tx  = rw_q;
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && cnt < FULL_BYTE) begin
                        shift_nx = shifted_in;
                        cnt_nx   = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            rx_data_nx  = shifted_in;
                            rx_valid_nx = 1'b1;
                        end
                    end else if (scl_fall && cnt == FULL_BYTE) begin
                        en_nx    = 1'b1;
                        state_nx = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        en_nx    = 1'b0;
                        cnt_nx   = '0;
                        state_nx = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt == FULL_BYTE) begin
                            en_nx    = 1'b0;
                            cnt_nx   = '0;
                            state_nx = RD_ACK;
                        end else begin
                            en_nx    = ~shift[I2C_DATA_W-1];
                            shift_nx = {shift[I2C_DATA_W-2:0], 1'b0};
                            cnt_nx   = cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // cnt doubles as the "master acknowledged" flag while in this state.
                    if (scl_rise && cnt == '0) begin
                        if (sda_lvl) begin
                            state_nx = WAIT_STOP;
                            busy_nx  = 1'b0;
                        end else begin
                            tx_req_nx = 1'b1;
                            cnt_nx    = 4'd1;
                        end
                    end else if (scl_fall && cnt == 4'd1) begin
                        load_tx = 1'b1;
                    end
                end
                WAIT_STOP: en_nx = 1'b0;
                default:   state_nx = IDLE;
            endcase

            // A new read byte puts its MSB on the bus on the same SCL fall it is loaded.
            if (load_tx) begin
                en_nx    = ~bus.tx_data[I2C_DATA_W-1];
                shift_nx = {bus.tx_data[I2C_DATA_W-2:0], 1'b0};
                cnt_nx   = 4'd1;
                state_nx = RD_BYTE;
            end
        end
    end

    assign bus.en_sda   = en_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.rw       = rw_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master plus a transaction-level model of what
// the target must do (ACK only its own address, report written bytes in order, put
// requested read bytes on the line, stay off the bus when not addressed).
// Define I2C_GLITCH_FILTER_EN for both RTL and bench to include the SCL glitch case.
`timescale 1ns/1ps
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] OWN = 7'h10;
    localparam int         Q   = 8;     // clocks per quarter SCL period

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_low = 1'b0;                 // master pulling SDA low
    logic [7:0] tx_byte = 8'h00;

    i2c_slave_if bus();

    // Open-drain wired-AND with pull-up.
    assign bus.sda     = ~(m_low | bus.en_sda);
    assign bus.tx_data = tx_byte;

    i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] exp_rxq[$];   // bytes the target must report via rx_valid, in order
    logic [7:0] txq[$];       // bytes handed to the target on each tx_req
    bit addressed = 1'b0;     // target is allowed to pull SDA
    bit exp_busy  = 1'b0;
    int rxv_count = 0;
    int txr_count = 0;
    bit prev_rxv  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                rxv_count++;
                chk("rx_valid single-cycle", 32'(prev_rxv), 32'd0);
                if (exp_rxq.size() == 0) chk("rx_valid unexpected", 32'd1, 32'd0);
                else                     chk("rx_data", 32'(bus.rx_data), 32'(exp_rxq.pop_front()));
            end
            prev_rxv = bus.rx_valid;
            if (bus.tx_req) begin
                txr_count++;
                if (txq.size() == 0) chk("tx_req unexpected", 32'd1, 32'd0);
                else                 tx_byte = txq.pop_front();
            end
            if (!addressed) chk("en_sda quiet", 32'(bus.en_sda), 32'd0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from idle (SCL high) or repeated START (SCL low).
    task automatic start_cond();
        if (!bus.scl) begin
            m_low = 1'b0; clks(Q);
            bus.scl = 1'b1; clks(Q);
        end
        m_low = 1'b1; clks(Q);
        addressed = 1'b0;
        exp_busy  = 1'b0;
        bus.scl = 1'b0; clks(Q);
    endtask

    task automatic stop_cond();
        m_low = 1'b1; clks(Q);
        bus.scl = 1'b1; clks(Q);
        m_low = 1'b0; clks(Q);
        addressed = 1'b0;
        exp_busy  = 1'b0;
        chk("busy after STOP", 32'(bus.busy), 32'd0);
        chk("en_sda after STOP", 32'(bus.en_sda), 32'd0);
        clks(Q);
    endtask

    // One SCL clock; master puts mbit (1 = release), checks target drive at mid-high.
    task automatic bit_xfer(input bit mbit, input bit slave_low, input string name, output bit seen);
        m_low = ~mbit; clks(Q);
        bus.scl = 1'b1; clks(Q);
        seen = bus.sda;
        chk({name, " en_sda"}, 32'(bus.en_sda), 32'(slave_low));
        chk({name, " busy"}, 32'(bus.busy), 32'(exp_busy));
        clks(Q);
        bus.scl = 1'b0; clks(Q);
    endtask

    task automatic addr_phase(input logic [6:0] a, input bit r, output bit acked);
        bit s;
        bit match;
        match = (a == OWN) && (a != 7'd0);
        for (int i = 7; i >= 1; i--) bit_xfer(a[i-1], 1'b0, "addr bit", s);
        if (match) begin
            addressed = 1'b1;
            exp_busy  = 1'b1;
        end
        bit_xfer(r, 1'b0, "rw bit", s);
        bit_xfer(1'b1, match, "addr ack", s);
        acked = !s;
        chk("addr ack on line", 32'(acked), 32'(match));
        if (match) chk("rw", 32'(bus.rw), 32'(r));
    endtask

    task automatic write_byte(input logic [7:0] b, input bit match);
        bit s;
        if (match) exp_rxq.push_back(b);
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, "wr bit", s);
        bit_xfer(1'b1, match, "wr ack", s);
    endtask

    task automatic read_byte(input logic [7:0] expb, input bit last, output logic [7:0] got);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, ~expb[i], "rd bit", s);
            got[i] = s;
        end
        if (last) begin
            addressed = 1'b0;
            exp_busy  = 1'b0;
        end
        bit_xfer(last, 1'b0, "rd master ack", s);
        chk("rd byte", 32'(got), 32'(expb));
    endtask

    logic [7:0] got;
    logic [7:0] rb[4];
    logic [6:0] ra;
    bit         ack, rnd_rw, s;
    int         n, r0, t0;

    initial begin
        bus.scl = 1'b1;
        clks(5);
        // Reset state
        chk("reset en_sda",   32'(bus.en_sda),   32'd0);
        chk("reset rx_data",  32'(bus.rx_data),  32'd0);
        chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset tx_req",   32'(bus.tx_req),   32'd0);
        chk("reset rw",       32'(bus.rw),       32'd0);
        chk("reset busy",     32'(bus.busy),     32'd0);
        rst_n = 1'b1;
        clks(5);

        // Write 0x10 W, 0xA5, STOP
        r0 = rxv_count;
        start_cond();
        addr_phase(OWN, 1'b0, ack);
        write_byte(8'hA5, 1'b1);
        stop_cond();
        chk("write A5 rx_data", 32'(bus.rx_data), 32'hA5);
        chk("write A5 rx_valid count", 32'(rxv_count - r0), 32'd1);

        // Foreign address 0x59: silent, no rx
        r0 = rxv_count;
        start_cond();
        addr_phase(7'h59, 1'b0, ack);
        write_byte(8'h5A, 1'b0);
        stop_cond();
        chk("foreign rx_valid count", 32'(rxv_count - r0), 32'd0);
        chk("foreign keeps rx_data", 32'(bus.rx_data), 32'hA5);

        // Read 0x10 R: 3C (ACK), C3 (NACK)
        txq.push_back(8'h3C);
        txq.push_back(8'hC3);
        t0 = txr_count;
        start_cond();
        addr_phase(OWN, 1'b1, ack);
        read_byte(8'h3C, 1'b0, got);
        chk("read byte 0 literal", 32'(got), 32'h3C);
        read_byte(8'hC3, 1'b1, got);
        chk("read byte 1 literal", 32'(got), 32'hC3);
        chk("after NACK state", 32'(dut.state), 32'(WAIT_STOP));
        chk("after NACK en_sda", 32'(bus.en_sda), 32'd0);
        chk("after NACK busy", 32'(bus.busy), 32'd0);
        chk("read tx_req count", 32'(txr_count - t0), 32'd2);
        stop_cond();
        chk("after STOP state", 32'(dut.state), 32'(IDLE));

        // Write 0x01 then repeated START into a read
        start_cond();
        addr_phase(OWN, 1'b0, ack);
        write_byte(8'h01, 1'b1);
        txq.push_back(8'h96);
        start_cond();
        chk("rep start rx_data", 32'(bus.rx_data), 32'h01);
        addr_phase(OWN, 1'b1, ack);
        chk("rep start rw", 32'(bus.rw), 32'd1);
        read_byte(8'h96, 1'b1, got);
        stop_cond();

        // General call is not acknowledged
        start_cond();
        addr_phase(7'h00, 1'b0, ack);
        chk("general call nack", 32'(ack), 32'd0);
        write_byte(8'hFF, 1'b0);
        stop_cond();

        // Reset during the 4th data bit of a read (target pulling SDA low)
        txq.push_back(8'hE0);
        start_cond();
        addr_phase(OWN, 1'b1, ack);
        for (int i = 7; i >= 5; i--) bit_xfer(1'b1, 1'b0, "pre-reset rd bit", s);
        m_low = 1'b0; clks(Q);
        bus.scl = 1'b1; clks(Q);
        chk("4th bit driven low", 32'(bus.en_sda), 32'd1);
        rst_n = 1'b0;
        #1;
        addressed = 1'b0;
        exp_busy  = 1'b0;
        txq.delete();
        chk("mid reset en_sda",   32'(bus.en_sda),   32'd0);
        chk("mid reset rx_data",  32'(bus.rx_data),  32'd0);
        chk("mid reset rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("mid reset tx_req",   32'(bus.tx_req),   32'd0);
        chk("mid reset rw",       32'(bus.rw),       32'd0);
        chk("mid reset busy",     32'(bus.busy),     32'd0);
        chk("mid reset state",    32'(dut.state),    32'(IDLE));
        clks(2);
        rst_n = 1'b1;
        clks(Q - 2);
        bus.scl = 1'b0; clks(Q);
        for (int i = 0; i < 5; i++) bit_xfer(1'b1, 1'b0, "post-reset bit", s);
        stop_cond();
        chk("post reset state", 32'(dut.state), 32'(IDLE));

        // Randomized transactions against the model
        for (int t = 0; t < 16; t++) begin
            ra     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OWN;
            rnd_rw = 1'($urandom);
            n      = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
            if (rnd_rw && ra == OWN) for (int k = 0; k < n; k++) txq.push_back(rb[k]);
            start_cond();
            addr_phase(ra, rnd_rw, ack);
            if (!rnd_rw) begin
                for (int k = 0; k < n; k++) write_byte(rb[k], ra == OWN);
            end else if (ra == OWN) begin
                for (int k = 0; k < n; k++) read_byte(rb[k], k == n - 1, got);
            end
            stop_cond();
        end

`ifdef I2C_GLITCH_FILTER_EN
        // 1-clk SCL glitch in the middle of a write bit must not shift an extra bit
        r0 = rxv_count;
        start_cond();
        addr_phase(OWN, 1'b0, ack);
        exp_rxq.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~(8'hA5 >> i) & 1'b1;
            clks(Q / 2);
            if (i == 4) begin
                bus.scl = 1'b1; clks(1);
                bus.scl = 1'b0; clks(Q / 2 - 1);
            end else begin
                clks(Q / 2);
            end
            bus.scl = 1'b1; clks(2 * Q);
            bus.scl = 1'b0; clks(Q);
        end
        bit_xfer(1'b1, 1'b1, "glitch wr ack", s);
        stop_cond();
        chk("glitch rx_data", 32'(bus.rx_data), 32'hA5);
        chk("glitch rx_valid count", 32'(rxv_count - r0), 32'd1);
`endif

        clks(4);
        chk("rx model drained", 32'(exp_rxq.size()), 32'd0);
        chk("tx model drained", 32'(txq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
